// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared opcode, branch-type and NIC-prefix constants plus the
//               packed decoded-bundle type used by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_R    = 6'b101010;
  localparam logic [5:0] OP_VBNZ = 6'b100010;
  localparam logic [5:0] OP_VBEZ = 6'b100011;
  localparam logic [5:0] OP_LD   = 6'b100000;
  localparam logic [5:0] OP_SD   = 6'b100001;
  localparam logic [5:0] OP_NOP  = 6'b111100;

  // Branch-type encodings
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_VBNZ = 2'b10;
  localparam logic [1:0] BR_VBEZ = 2'b11;

  // mem_addr[15:14] value that routes a load/store to the NIC
  localparam logic [1:0] NIC_PREFIX = 2'b11;

  // Decoded fields. The NIC select is derived from mem_addr at the output so
  // the struct stays independent of the NIC_SEL_W parameter.
  typedef struct packed {
    logic [4:0]  rs_a;
    logic [4:0]  rs_b;
    logic [4:0]  rd;
    logic [4:0]  hdu_a;
    logic [4:0]  hdu_b;
    logic [1:0]  ww;
    logic [5:0]  op;
    logic [2:0]  ppp;
    logic [1:0]  br;
    logic [15:0] imm;
    logic [15:0] mem_addr;
    logic        wr_en;
    logic        mem_en;
    logic        store;
    logic        load;
    logic        nic_en;
    logic        nic_wr;
    logic        illegal;
  } dec_bundle_t;

endpackage : decode_pkg
`default_nettype wire

// File: rtl/decode_fifo.sv
`default_nettype none
// ============================================================================
// Module      : decode_fifo
// Description : Synchronous instruction buffer, DEPTH entries (power of two).
//               Head word is presented combinationally; flush empties it.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               flush_i         - empty the buffer this cycle, ignore push
//               push_i/push_data_i - write request and data (dropped if full)
//               pop_i           - consume head (ignored if empty)
//               head_o          - current head word
//               empty_o/full_o  - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module decode_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only consumed when count is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i && w_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : decode_fifo
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pipe
// Description : Buffered, registered instruction decoder with load-use
//               interlock, illegal-opcode flag and pipeline flush.
// Ports       : clk, reset             - clock, synchronous active-high reset
//               flush                  - drop everything buffered/registered
//               in_valid/in_instr/in_ready    - fetch side handshake
//               out_valid/out_ready           - downstream handshake
//               out_rs_a/rs_b/rd/hdu_a/hdu_b  - register addresses
//               out_ww/op/ppp/br/imm/mem_addr - decoded fields
//               out_wr_en/mem_en/store/load   - controls
//               out_nic_en/nic_wr/nic_sel     - NIC access controls
//               out_illegal                   - unrecognised opcode
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int LD_STALL  = 1,
  parameter int NIC_SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_rs_a,
  output logic [4:0]           out_rs_b,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_hdu_a,
  output logic [4:0]           out_hdu_b,
  output logic [1:0]           out_ww,
  output logic [5:0]           out_op,
  output logic [2:0]           out_ppp,
  output logic [1:0]           out_br,
  output logic [15:0]          out_imm,
  output logic [15:0]          out_mem_addr,
  output logic                 out_wr_en,
  output logic                 out_mem_en,
  output logic                 out_store,
  output logic                 out_load,
  output logic                 out_nic_en,
  output logic                 out_nic_wr,
  output logic [NIC_SEL_W-1:0] out_nic_sel,
  output logic                 out_illegal
);

  localparam int             SCW        = (LD_STALL > 0) ? $clog2(LD_STALL + 1) : 1;
  localparam logic [SCW-1:0] STALL_INIT = SCW'(LD_STALL);

  // --------------------------------------------------------------------------
  // Decode helpers
  // --------------------------------------------------------------------------
  function automatic dec_bundle_t decode(input logic [31:0] instr);
    dec_bundle_t d;
    d = '0;
    case (instr[31:26])
      OP_R: begin
        d.rd    = instr[25:21];
        d.rs_a  = instr[20:16];
        d.rs_b  = instr[15:11];
        d.hdu_a = instr[20:16];
        d.hdu_b = instr[15:11];
        d.ppp   = instr[10:8];
        d.ww    = instr[7:6];
        d.op    = instr[5:0];
        d.wr_en = 1'b1;
      end
      OP_VBNZ, OP_VBEZ: begin
        d.rs_a  = instr[25:21];
        d.hdu_a = instr[25:21];
        d.br    = (instr[31:26] == OP_VBNZ) ? BR_VBNZ : BR_VBEZ;
        d.imm   = instr[15:0];
      end
      OP_LD: begin
        d.rd       = instr[25:21];
        d.hdu_a    = instr[25:21];
        d.mem_addr = instr[15:0];
        d.mem_en   = 1'b1;
        d.load     = 1'b1;
        d.wr_en    = 1'b1;
      end
      OP_SD: begin
        d.rs_a     = instr[25:21];
        d.hdu_a    = instr[25:21];
        d.mem_addr = instr[15:0];
        d.mem_en   = 1'b1;
        d.store    = 1'b1;
      end
      OP_NOP: begin
        d.ppp = instr[10:8];
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    if ((d.load || d.store) && (d.mem_addr[15:14] == NIC_PREFIX)) begin
      d.nic_en = 1'b1;
      d.nic_wr = d.store;
    end
    return d;
  endfunction

  // True when the instruction reads register r as a source operand.
  function automatic logic reads_reg(input logic [31:0] instr, input logic [4:0] r);
    logic hit;
    hit = 1'b0;
    case (instr[31:26])
      OP_R:                    hit = (instr[20:16] == r) || (instr[15:11] == r);
      OP_VBNZ, OP_VBEZ, OP_SD: hit = (instr[25:21] == r);
      default:                 hit = 1'b0;
    endcase
    return hit;
  endfunction

  // --------------------------------------------------------------------------
  // Instruction buffer
  // --------------------------------------------------------------------------
  logic [31:0] w_head;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_issue;

  // Full blocks fetch even when the head pops the same cycle, keeping
  // in_ready a pure function of registered occupancy and flush.
  assign in_ready = !w_full && !flush;
  assign w_push   = in_valid && in_ready;

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .push_i      (w_push),
    .push_data_i (in_instr),
    .pop_i       (w_issue),
    .head_o      (w_head),
    .empty_o     (w_empty),
    .full_o      (w_full)
  );

  // --------------------------------------------------------------------------
  // Interlock and output register
  // --------------------------------------------------------------------------
  dec_bundle_t    w_dec;
  dec_bundle_t    bundle_q;
  dec_bundle_t    bundle_d;
  logic           out_valid_q;
  logic           out_valid_d;
  logic [SCW-1:0] stall_q;
  logic [SCW-1:0] stall_d;
  logic [4:0]     ld_rd_q;
  logic [4:0]     ld_rd_d;
  logic           w_dep;
  logic           w_load_out;

  always_comb begin
    w_dec       = decode(w_head);
    w_dep       = (stall_q != '0) && reads_reg(w_head, ld_rd_q);
    w_load_out  = !out_valid_q || out_ready;
    w_issue     = !w_empty && w_load_out && !w_dep && !flush;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    stall_d     = stall_q;
    ld_rd_d     = ld_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
      bundle_d    = '0;
      stall_d     = '0;
    end else begin
      // A held dependent head turns a free output slot into a bubble.
      if (w_load_out) begin
        out_valid_d = w_issue;
        bundle_d    = w_issue ? w_dec : '0;
      end
      // Stall counts downstream-ready cycles; a new LD restarts the window.
      if (w_issue && w_dec.load) begin
        stall_d = STALL_INIT;
        ld_rd_d = w_dec.rd;
      end else if (out_ready && (stall_q != '0)) begin
        stall_d = stall_q - SCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      stall_q     <= '0;
      ld_rd_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      stall_q     <= stall_d;
      ld_rd_q     <= ld_rd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid    = out_valid_q;
  assign out_rs_a     = bundle_q.rs_a;
  assign out_rs_b     = bundle_q.rs_b;
  assign out_rd       = bundle_q.rd;
  assign out_hdu_a    = bundle_q.hdu_a;
  assign out_hdu_b    = bundle_q.hdu_b;
  assign out_ww       = bundle_q.ww;
  assign out_op       = bundle_q.op;
  assign out_ppp      = bundle_q.ppp;
  assign out_br       = bundle_q.br;
  assign out_imm      = bundle_q.imm;
  assign out_mem_addr = bundle_q.mem_addr;
  assign out_wr_en    = bundle_q.wr_en;
  assign out_mem_en   = bundle_q.mem_en;
  assign out_store    = bundle_q.store;
  assign out_load     = bundle_q.load;
  assign out_nic_en   = bundle_q.nic_en;
  assign out_nic_wr   = bundle_q.nic_wr;
  assign out_illegal  = bundle_q.illegal;
  assign out_nic_sel  = bundle_q.nic_en ? bundle_q.mem_addr[NIC_SEL_W-1:0] : '0;

endmodule : decode_stage_pipe
`default_nettype wire

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Pipelined, parametrised successor to the combinational instruction decoder. It buffers fetched instructions in a small FIFO and decodes the FIFO head. Decoded fields are registered behind a valid/ready handshake. It adds a load-use interlock, an illegal-opcode flag and flush support. It sits between fetch and the register-file/execute stage.

## Interface
Parameters:
- DEPTH, 2: input FIFO entries; power of two, at least 2.
- LD_STALL, 1: issue slots a dependent instruction is held after an LD issues; 0 disables the interlock.
- NIC_SEL_W, 2: low memory-address bits used as the NIC register select.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch offers an instruction.
- in_instr  in  32  instruction word.
- in_ready  out  1  FIFO not full.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_rs_a, out_rs_b, out_rd  out  5 each  operand A, operand B and destination addresses.
- out_hdu_a, out_hdu_b  out  5 each  hazard-unit source addresses.
- out_ww  out  2  write width.
- out_op  out  6  operation code.
- out_ppp  out  3  participation field.
- out_br  out  2  branch type: 00 none, 10 VBNZ, 11 VBEZ.
- out_imm  out  16  branch immediate.
- out_mem_addr  out  16  memory address.
- out_wr_en, out_mem_en, out_store, out_load  out  1 each  register-write, memory-enable, store and load controls.
- out_nic_en, out_nic_wr  out  1 each  NIC access and NIC write.
- out_nic_sel  out  NIC_SEL_W  equals mem_addr[NIC_SEL_W-1:0] on a NIC access, else 0.
- out_illegal  out  1  opcode not recognised.

## Operation
Opcode is instr[31:26].

- **R-type (101010):**
  - rs_a=[20:16], rs_b=[15:11], rd=[25:21].
  - ww=[7:6], op=[5:0], ppp=[10:8].
  - wr_en=1.
  - hdu_a=rs_a, hdu_b=rs_b.
- **VBNZ (100010) / VBEZ (100011):**
  - rs_a=hdu_a=[25:21].
  - br=10 or 11 respectively; imm=[15:0].
  - wr_en=0.
- **LD (100000):**
  - rd=hdu_a=[25:21], mem_addr=[15:0].
  - mem_en=1, load=1, wr_en=1.
- **SD (100001):**
  - rs_a=hdu_a=[25:21], mem_addr=[15:0].
  - mem_en=1, store=1.
- **NOP (111100):** all controls 0; ppp=[10:8].
- **Other opcodes:** all fields 0, illegal=1. The bundle is still issued.
- **NIC access:** LD/SD with mem_addr[15:14]=11 sets nic_en=1 and nic_wr=store.

Every field not listed for a class is 0, including ppp for illegal opcodes.

Sources for the interlock:
- R-type reads rs_a and rs_b.
- Branch and SD read rs_a.
- LD and NOP read nothing.

Interlock:
- Issuing an LD loads ld_rd and sets stall_cnt=LD_STALL.
- stall_cnt decrements on each cycle with out_ready=1, saturating at 0.
- While stall_cnt>0 and the head reads ld_rd, the head is not issued.
  - If the output register is free, a bubble is issued (out_valid=0).
- A non-dependent head issues normally.

## Timing
- **Reset:** all outputs 0, FIFO empty, stall_cnt=0, in_ready=1 on the first cycle after reset deasserts.
- **Accept:** on in_valid&&in_ready.
- **Latency:** an instruction accepted in cycle N into an empty pipe has out_valid=1 in cycle N+2 (FIFO write, then decode and register).
- **Throughput:** one per cycle with DEPTH≥2 and out_ready held high.
- **Full FIFO:** in_ready=0 when full, even if a pop occurs the same cycle.
- **Empty FIFO:** simultaneous push and pop allowed; FIFO pointers wrap modulo DEPTH.
- **Output register:** loads when !out_valid || out_ready.
- **Backpressure:** holds when out_valid && !out_ready; all outputs stay stable until accepted.
- **Flush:** in the flush cycle, the FIFO empties, out_valid clears and stall_cnt clears. in_valid is ignored that cycle and in_ready=0.
- **Reset precedence:** reset has priority over flush. Mid-operation reset behaves exactly as power-on reset.

## Structure
- Shared package `decode_pkg` holds:
  - opcode localparams OP_R, OP_VBNZ, OP_VBEZ, OP_LD, OP_SD, OP_NOP;
  - BR_* encodings;
  - the NIC address prefix 2'b11;
  - a packed struct dec_bundle_t for the output fields.
- One sub-module, `decode_fifo` (parametrised by DEPTH, width 32), provides the instruction buffer.
- The decode function and the interlock live in the top module.

## Test plan
- **Back-to-back R-types:** three R-types with out_ready=1, e.g. 0xA8A31A45 (rd=5, rs_a=3, rs_b=3, ppp=2, ww=1, op=5). Expect three consecutive out_valid cycles starting 2 cycles after the first accept, with fields matching.
- **Load-use, dependent:** LD r4 then R-type reading r4 with LD_STALL=1. Expect exactly one bubble between the two bundles.
- **Load-use, independent:** LD r4 then R-type reading r6. Expect no bubble.
- **NIC decode:** SD with mem_addr=0xC003, then LD with mem_addr=0xC000. Expect nic_en=1 on both; nic_wr=1 for SD and 0 for LD; nic_sel=3 and 0 respectively.
- **Backpressure and full:** hold out_ready=0 and push 4 instructions with DEPTH=2. Expect in_ready to drop after 2 enqueued plus 1 in the output register, and outputs stable. On release, expect in-order drain.
- **Illegal opcode and flush:** illegal opcode 0x3F. Expect out_illegal=1 and all controls 0. Separately, assert flush with 2 queued instructions. Expect out_valid=0 next cycle and no stale bundle after refill.
